route_cmd_seq: RTL and testbench
================================

// Module: route_cmd_seq
// PURPOSE
// Parametrised successor of the line-follower command processor. Accepts route commands from the UART wrapper
// and buffers them in a FIFO_DEPTH-entry queue. Each command is a string of 2-bit turn codes consumed LSB first.
// Drives go, buzz and the open-loop steering error err_opn_lp into the PID/motor path; adds command queuing,
// parametrised magnitudes/timers and bump handling in every active state.
// PARAMETERS
// CMD_W      16        command width; must be even; NUM_CODES = CMD_W/2
// FIFO_DEPTH 4         queued commands (power of 2, >=2)
// ERR_W      16        err_opn_lp width (two's complement)
// VEER_MAG   'h340     veer error magnitude
// REV1_MAG   'h1E0     reverse phase-1 magnitude
// REV2_MAG   'h380     reverse phase-2 magnitude
// REV1_CYC   2883584   reverse phase-1 duration (clk cycles)
// REV2_CYC   65011712  reverse phase-2 duration (clk cycles)
// DBNC_CYC   4194304   bump debounce/min buzz duration (clk cycles)
// TMR_W      26        timer width; must hold max(REV1_CYC,REV2_CYC,DBNC_CYC)
// PORTS
// clk          in  1      clock
// rst          in  1      synchronous active-high reset
// cmd          in  CMD_W  command from UART wrapper
// cmd_rdy      in  1      command valid
// clr_cmd_rdy  out 1      combinational ack: cmd_rdy & ~q_full
// line_present in  1      line sensor sees line
// BMPL_n       in  1      left bumper, active low
// BMPR_n       in  1      right bumper, active low
// go           out 1      motors enabled
// buzz         out 1      piezo drive
// err_opn_lp   out ERR_W  open-loop steering error
// q_cnt        out $clog2(FIFO_DEPTH)+1  queued command count
// q_full       out 1      q_cnt==FIFO_DEPTH
// BEHAVIOUR
// - rst: state IDLE, queue empty, shift reg 0, last_veer_right 0, timer 0; go=0, buzz=0, err_opn_lp=0.
// - Push: clr_cmd_rdy=1 and entry written at same edge when cmd_rdy & ~q_full; full -> cmd_rdy left pending.
//   Push ignores a same-cycle pop (no push-through when full); push+pop same cycle keeps q_cnt.
// - Codes: 00 end-of-command, 01 veer right (+VEER_MAG), 10 veer left (-VEER_MAG), 11 reverse.
// - IDLE: go=0, err=0; q_cnt>0 & line_present -> pop into shift reg, go=1 same cycle, -> FOLLOW.
// - Bump (~BMPL_n|~BMPR_n) in FOLLOW/VEER/REV1/REV2/REACQ has priority: timer cleared, -> BMP_DBNC; code not
//   shifted, so a maneuver aborted by a bump restarts from FOLLOW.
// - FOLLOW: go=1, err=0. Line lost: code 00 -> IDLE (go=0 from next cycle); 01/10 -> VEER; 11 -> REV1 (timer cleared).
// - VEER: go=1, err=+/-VEER_MAG; line_present -> shift 2, last_veer_right=code[0], -> FOLLOW.
// - REV1: err = last_veer_right ? +REV1_MAG : -REV1_MAG; after REV1_CYC cycles clear timer -> REV2.
// - REV2: opposite sign, REV2_MAG, REV2_CYC cycles -> REACQ. REACQ: err=0, go=1; line_present -> shift, -> FOLLOW.
//   Reverse never updates last_veer_right.
// - BMP_DBNC: go=0, buzz=1, err=0 for DBNC_CYC cycles; then both bumpers released -> FOLLOW else -> BMP_HOLD.
// - BMP_HOLD: go=0, buzz=1 until both released -> FOLLOW (buzz=0 that cycle).
// - All outputs combinational from state/shift reg/timer; timer saturates at all-ones; negation mod 2^ERR_W.
// - Exhausted command (all codes shifted) yields 00 -> IDLE; queued next command loads when line_present.
// CONFIGURATION
// - BUZZ_TONE_EN defined: buzz is a square wave toggling every 2^12 clk while buzzing (divider cleared on entry
//   to BMP_DBNC, output starts high). Undefined: buzz is a steady level, divider not instantiated.
// TESTING (REV1_CYC=10, REV2_CYC=16, DBNC_CYC=8, FIFO_DEPTH=4)
// - cmd=16'h0001, line_present=1 -> clr_cmd_rdy 1 cycle, go=1 next cycle; drop line -> err=16'h0340 until line back.
// - cmd=16'h0009 (01 then 10): veer +340, line back, lose again -> err=16'hFCC0; third loss -> IDLE, go=0.
// - after veer right, code 11: err=16'h01E0 for 10 cycles, 16'hFC80 for 16 cycles, 0 until line_present.
// - 5 back-to-back cmd_rdy while IDLE, line absent -> 4 acks, q_full=1, 5th pending until first pop.
// - BMPL_n low 3 cycles during FOLLOW -> go=0, buzz=1 exactly 8 cycles, then FOLLOW; held low -> buzz until release.
// - rst high mid-REV2 -> next cycle IDLE, go=0, err=0, q_cnt=0.

Source files
------------

// File: rtl/route_cmd_seq.sv
// Route command sequencer: queues turn-code commands and drives go/buzz/err_opn_lp for the motor path.
// Optional BUZZ_TONE_EN macro turns the steady buzz level into a 2^12-cycle square wave.
module route_cmd_seq #(
  parameter int CMD_W      = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 16,
  parameter int VEER_MAG   = 32'h0000_0340,
  parameter int REV1_MAG   = 32'h0000_01E0,
  parameter int REV2_MAG   = 32'h0000_0380,
  parameter int REV1_CYC   = 32'd2883584,
  parameter int REV2_CYC   = 32'd65011712,
  parameter int DBNC_CYC   = 32'd4194304,
  parameter int TMR_W      = 26
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CMD_W-1:0]              cmd,
  input  logic                          cmd_rdy,
  output logic                          clr_cmd_rdy,
  input  logic                          line_present,
  input  logic                          BMPL_n,
  input  logic                          BMPR_n,
  output logic                          go,
  output logic                          buzz,
  output logic [ERR_W-1:0]              err_opn_lp,
  output logic [$clog2(FIFO_DEPTH):0]   q_cnt,
  output logic                          q_full
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int QW = PW + 1;
  localparam logic [ERR_W-1:0] VEER_P = ERR_W'(VEER_MAG);
  localparam logic [ERR_W-1:0] VEER_N = ERR_W'(-VEER_MAG);
  localparam logic [ERR_W-1:0] REV1_P = ERR_W'(REV1_MAG);
  localparam logic [ERR_W-1:0] REV1_N = ERR_W'(-REV1_MAG);
  localparam logic [ERR_W-1:0] REV2_P = ERR_W'(REV2_MAG);
  localparam logic [ERR_W-1:0] REV2_N = ERR_W'(-REV2_MAG);
  localparam logic [TMR_W-1:0] REV1_LAST = TMR_W'(REV1_CYC - 32'sd1);
  localparam logic [TMR_W-1:0] REV2_LAST = TMR_W'(REV2_CYC - 32'sd1);
  localparam logic [TMR_W-1:0] DBNC_LAST = TMR_W'(DBNC_CYC - 32'sd1);

  typedef enum logic [2:0] {
    IDLE, FOLLOW, VEER, REV1, REV2, REACQ, BMP_DBNC, BMP_HOLD
  } state_t;

  state_t               state_r, state_s;
  logic [CMD_W-1:0]     fifo_r [FIFO_DEPTH];
  logic [PW-1:0]        wr_ptr_r, rd_ptr_r;
  logic [QW-1:0]        q_cnt_r;
  logic [CMD_W-1:0]     shift_r;
  logic                 last_veer_right_r;
  logic [TMR_W-1:0]     timer_r;
  logic                 push_s, pop_s, shift_en_s, lvr_upd_s, timer_clr_s;
  logic                 go_s, buzz_s, bump_s, full_s;
  logic [ERR_W-1:0]     err_s;
  logic [1:0]           code_s;

  assign full_s = (q_cnt_r == QW'(FIFO_DEPTH));
  assign push_s = cmd_rdy & ~full_s;
  assign bump_s = ~BMPL_n | ~BMPR_n;
  assign code_s = shift_r[1:0];

  // Next-state and output decode; bumps in any maneuvering state override the normal transition.
  always_comb begin
    state_s     = state_r;
    pop_s       = 1'b0;
    shift_en_s  = 1'b0;
    lvr_upd_s   = 1'b0;
    timer_clr_s = 1'b0;
    go_s        = 1'b0;
    buzz_s      = 1'b0;
    err_s       = '0;
    case (state_r)
      IDLE: begin
        if ((q_cnt_r != '0) && line_present) begin
          pop_s   = 1'b1;
          go_s    = 1'b1;
          state_s = FOLLOW;
        end else begin
          state_s = IDLE;
        end
      end
      FOLLOW: begin
        go_s = 1'b1;
        if (!line_present) begin
          case (code_s)
            2'b00:   state_s = IDLE;
            2'b11: begin
              state_s     = REV1;
              timer_clr_s = 1'b1;
            end
            default: state_s = VEER;
          endcase
        end else begin
          state_s = FOLLOW;
        end
      end
      VEER: begin
        go_s  = 1'b1;
        err_s = code_s[0] ? VEER_P : VEER_N;
        if (line_present) begin
          shift_en_s = 1'b1;
          lvr_upd_s  = 1'b1;
          state_s    = FOLLOW;
        end else begin
          state_s = VEER;
        end
      end
      REV1: begin
        go_s  = 1'b1;
        err_s = last_veer_right_r ? REV1_P : REV1_N;
        if (timer_r == REV1_LAST) begin
          timer_clr_s = 1'b1;
          state_s     = REV2;
        end else begin
          state_s = REV1;
        end
      end
      REV2: begin
        go_s  = 1'b1;
        err_s = last_veer_right_r ? REV2_N : REV2_P;
        if (timer_r == REV2_LAST) begin
          state_s = REACQ;
        end else begin
          state_s = REV2;
        end
      end
      REACQ: begin
        go_s = 1'b1;
        if (line_present) begin
          shift_en_s = 1'b1;
          state_s    = FOLLOW;
        end else begin
          state_s = REACQ;
        end
      end
      BMP_DBNC: begin
        buzz_s = 1'b1;
        if (timer_r == DBNC_LAST) begin
          state_s = bump_s ? BMP_HOLD : FOLLOW;
        end else begin
          state_s = BMP_DBNC;
        end
      end
      BMP_HOLD: begin
        if (bump_s) begin
          buzz_s  = 1'b1;
          state_s = BMP_HOLD;
        end else begin
          state_s = FOLLOW;
        end
      end
      default: state_s = IDLE;
    endcase
    if (bump_s && (state_r inside {FOLLOW, VEER, REV1, REV2, REACQ})) begin
      state_s     = BMP_DBNC;
      timer_clr_s = 1'b1;
      shift_en_s  = 1'b0;
      lvr_upd_s   = 1'b0;
    end else begin
      state_s = state_s;
    end
  end

  // State, queue bookkeeping, shift register and saturating timer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r           <= IDLE;
      wr_ptr_r          <= '0;
      rd_ptr_r          <= '0;
      q_cnt_r           <= '0;
      shift_r           <= '0;
      last_veer_right_r <= 1'b0;
      timer_r           <= '0;
    end else begin
      state_r <= state_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(32'd1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(32'd1);
      case ({push_s, pop_s})
        2'b10:   q_cnt_r <= q_cnt_r + QW'(32'd1);
        2'b01:   q_cnt_r <= q_cnt_r - QW'(32'd1);
        default: q_cnt_r <= q_cnt_r;
      endcase
      if (pop_s)           shift_r <= fifo_r[rd_ptr_r];
      else if (shift_en_s) shift_r <= {2'b00, shift_r[CMD_W-1:2]};
      if (lvr_upd_s) last_veer_right_r <= code_s[0];
      if (timer_clr_s)           timer_r <= '0;
      else if (timer_r != '1)    timer_r <= timer_r + TMR_W'(32'd1);
    end
  end

  // Command storage; contents are only meaningful where q_cnt says so.
  always_ff @(posedge clk) begin
    if (push_s) fifo_r[wr_ptr_r] <= cmd;
  end

`ifdef BUZZ_TONE_EN
  logic [11:0] div_r;
  logic        tone_r;

  // Tone divider restarts high on every fresh bump so each buzz begins audibly.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_r  <= 12'd0;
      tone_r <= 1'b1;
    end else if ((state_s == BMP_DBNC) && (state_r != BMP_DBNC)) begin
      div_r  <= 12'd0;
      tone_r <= 1'b1;
    end else if (buzz_s) begin
      div_r <= div_r + 12'd1;
      if (div_r == 12'hFFF) tone_r <= ~tone_r;
    end
  end

  assign buzz = buzz_s & tone_r;
`else
  assign buzz = buzz_s;
`endif

  assign clr_cmd_rdy = push_s;
  assign go          = go_s;
  assign err_opn_lp  = err_s;
  assign q_cnt       = q_cnt_r;
  assign q_full      = full_s;

endmodule

// File: tb/tb_route_cmd_seq.sv
// Directed table-driven bench for route_cmd_seq with shortened timers (REV1 10, REV2 16, debounce 8).
module tb_route_cmd_seq;

  logic        clk = 1'b0;
  logic        rst, cmd_rdy, line_present, BMPL_n, BMPR_n;
  logic [15:0] cmd;
  logic        clr_cmd_rdy, go, buzz, q_full;
  logic [15:0] err_opn_lp;
  logic [2:0]  q_cnt;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] RL = 2'b11;  // {BMPL_n, BMPR_n}: both released
  localparam logic [1:0] BL = 2'b01;  // left bumper pressed
  localparam logic [1:0] BR = 2'b10;  // right bumper pressed

  typedef struct {
    logic        rst;
    logic [15:0] cmd;
    logic        rdy, line;
    logic [1:0]  bmp;
    logic        clr, go, buzz;
    logic [15:0] err;
    logic [2:0]  qc;
    logic        full;
  } vec_t;

  vec_t vq[$];

  always #5 clk = ~clk;

  route_cmd_seq #(
    .FIFO_DEPTH(4), .REV1_CYC(10), .REV2_CYC(16), .DBNC_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy),
    .line_present(line_present), .BMPL_n(BMPL_n), .BMPR_n(BMPR_n),
    .go(go), .buzz(buzz), .err_opn_lp(err_opn_lp), .q_cnt(q_cnt), .q_full(q_full)
  );

  task automatic add(input logic r, input logic [15:0] c, input logic rdy, input logic line,
                     input logic [1:0] bmp, input logic clr, input logic g, input logic bz,
                     input logic [15:0] e, input logic [2:0] qc, input logic full);
    vec_t v;
    v.rst = r; v.cmd = c; v.rdy = rdy; v.line = line; v.bmp = bmp;
    v.clr = clr; v.go = g; v.buzz = bz; v.err = e; v.qc = qc; v.full = full;
    vq.push_back(v);
  endtask

  task automatic drive(input logic r, input logic [15:0] c, input logic rdy, input logic line,
                       input logic [1:0] bmp);
    @(negedge clk);
    rst = r; cmd = c; cmd_rdy = rdy; line_present = line;
    BMPL_n = bmp[1]; BMPR_n = bmp[0];
    #1;
  endtask

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  initial begin
    rst = 1'b1; cmd = 16'h0000; cmd_rdy = 1'b0; line_present = 1'b0; BMPL_n = 1'b1; BMPR_n = 1'b1;
    repeat (2) @(posedge clk);

    // single veer right, then exhausted command returns to IDLE
    add(1'b0, 16'h0001, 1'b1, 1'b1, RL, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    for (int i = 0; i < 2; i++)
      add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0340, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0340, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    // 0x0009: veer right, veer left, end
    add(1'b0, 16'h0009, 1'b1, 1'b0, RL, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0340, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0340, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'hFCC0, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'hFCC0, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    // 0x000D: veer right then reverse
    add(1'b0, 16'h000D, 1'b1, 1'b0, RL, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0340, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h01E0, 3'd0, 1'b0);
    for (int i = 0; i < 16; i++)
      add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'hFC80, 3'd0, 1'b0);
    for (int i = 0; i < 2; i++)
      add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    // five back-to-back commands with line absent: queue fills, fifth waits for a pop
    add(1'b0, 16'h0000, 1'b1, 1'b0, RL, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0002, 1'b1, 1'b0, RL, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd1, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b0, RL, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd2, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b0, RL, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd3, 1'b0);
    add(1'b0, 16'h0000, 1'b1, 1'b0, RL, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b1);
    add(1'b0, 16'h0000, 1'b1, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd4, 1'b1);
    add(1'b0, 16'h0000, 1'b1, 1'b1, RL, 1'b1, 1'b1, 1'b0, 16'h0000, 3'd3, 1'b0);
    // short left bump in FOLLOW: exactly 8 buzz cycles
    add(1'b0, 16'h0000, 1'b0, 1'b1, BL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd4, 1'b1);
    for (int i = 0; i < 2; i++)
      add(1'b0, 16'h0000, 1'b0, 1'b1, BL, 1'b0, 1'b0, 1'b1, 16'h0000, 3'd4, 1'b1);
    for (int i = 0; i < 6; i++)
      add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b0, 1'b1, 16'h0000, 3'd4, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd4, 1'b1);
    // right bump held past debounce: buzz until release
    add(1'b0, 16'h0000, 1'b0, 1'b1, BR, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd4, 1'b1);
    for (int i = 0; i < 10; i++)
      add(1'b0, 16'h0000, 1'b0, 1'b1, BR, 1'b0, 1'b0, 1'b1, 16'h0000, 3'd4, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd4, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd4, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd4, 1'b1);
    // second queued command (0x0002, veer left) then bump aborts the veer
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd4, 1'b1);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd3, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'hFCC0, 3'd3, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, BL, 1'b0, 1'b1, 1'b0, 16'hFCC0, 3'd3, 1'b0);
    for (int i = 0; i < 8; i++)
      add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b0, 1'b1, 16'h0000, 3'd3, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd3, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'hFCC0, 3'd3, 1'b0);
    // reset, then reverse with last_veer_right cleared, reset again mid-REV2
    add(1'b1, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'hFCC0, 3'd3, 1'b0);
    add(1'b0, 16'h0003, 1'b1, 1'b0, RL, 1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b1, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd1, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0000, 3'd0, 1'b0);
    for (int i = 0; i < 10; i++)
      add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'hFE20, 3'd0, 1'b0);
    for (int i = 0; i < 5; i++)
      add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0380, 3'd0, 1'b0);
    add(1'b1, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b1, 1'b0, 16'h0380, 3'd0, 1'b0);
    add(1'b0, 16'h0000, 1'b0, 1'b0, RL, 1'b0, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0);

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rst, vq[i].cmd, vq[i].rdy, vq[i].line, vq[i].bmp);
      chk("clr_cmd_rdy", i, {15'd0, clr_cmd_rdy}, {15'd0, vq[i].clr});
      chk("go",          i, {15'd0, go},          {15'd0, vq[i].go});
      chk("buzz",        i, {15'd0, buzz},        {15'd0, vq[i].buzz});
      chk("err_opn_lp",  i, err_opn_lp,           vq[i].err);
      chk("q_cnt",       i, {13'd0, q_cnt},       {13'd0, vq[i].qc});
      chk("q_full",      i, {15'd0, q_full},      {15'd0, vq[i].full});
    end

    // bump during REV1 aborts the reverse; it restarts from FOLLOW with a fresh timer
    drive(1'b0, 16'h0003, 1'b1, 1'b0, RL);
    chk("rb_ack", 0, {15'd0, clr_cmd_rdy}, 16'h0001);
    drive(1'b0, 16'h0000, 1'b0, 1'b1, RL);
    chk("rb_pop_go", 1, {15'd0, go}, 16'h0001);
    drive(1'b0, 16'h0000, 1'b0, 1'b0, RL);
    chk("rb_follow_err", 2, err_opn_lp, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0000, 1'b0, 1'b0, RL);
      chk("rb_rev1_err", 3 + i, err_opn_lp, 16'hFE20);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, BR);
    chk("rb_bump_err", 6, err_opn_lp, 16'hFE20);
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 16'h0000, 1'b0, 1'b0, RL);
      chk("rb_dbnc_buzz", 7 + i, {15'd0, buzz}, 16'h0001);
      chk("rb_dbnc_go",   7 + i, {15'd0, go},   16'h0000);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, RL);
    chk("rb_refollow_go",  15, {15'd0, go}, 16'h0001);
    chk("rb_refollow_err", 15, err_opn_lp,  16'h0000);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 16'h0000, 1'b0, 1'b0, RL);
      chk("rb_rev1_again", 16 + i, err_opn_lp, 16'hFE20);
    end
    drive(1'b0, 16'h0000, 1'b0, 1'b0, RL);
    chk("rb_rev2_entry", 26, err_opn_lp, 16'h0380);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
